// File: rtl/rvtu_tag_pkg.sv
// Shared types and sizes for the RVTU tag SRAM controller.
package rvtu_tag_pkg;

  localparam int IDX_W   = 7;
  localparam int TAG_W   = 21;
  localparam int DEPTH   = 2 ** IDX_W;
  localparam int ENTRY_W = TAG_W + 1;

  // One tag SRAM word: valid bit on top, tag below.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  // SWEEP clears every entry; IDLE arbitrates lookups and writes.
  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } tag_ctrl_state_t;

endpackage

// File: rtl/rvtu_tag_ctrl.sv
// Controller and arbiter for the single-port RVTU tag SRAM. Shares the one
// array port between lookups, writes and an invalidate sweep that runs after
// reset and on flush_req. Lookup results come back one cycle after acceptance.
module rvtu_tag_ctrl
  import rvtu_tag_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  // lookup request
  input  logic               lk_valid,
  output logic               lk_ready,
  input  logic [IDX_W-1:0]   lk_idx,
  input  logic [TAG_W-1:0]   lk_tag,
  // lookup response
  output logic               rsp_valid,
  output logic               rsp_hit,
  output logic [ENTRY_W-1:0] rsp_entry,
  // write request
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [ENTRY_W-1:0] wr_entry,
  // flush engine
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               flush_done,
  // SRAM port
  output logic [IDX_W-1:0]   sram_addr,
  output logic [ENTRY_W-1:0] sram_wdata,
  output logic               sram_wen,
  input  logic [ENTRY_W-1:0] sram_rdata
);

  tag_ctrl_state_t  state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic             rsp_pend_q, rsp_pend_d;
  logic             done_q, done_d;

  tag_entry_t       rd_entry;

  // Next-state, arbitration and SRAM port drive for the current cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    tag_d      = tag_q;
    rsp_pend_d = 1'b0;
    done_d     = 1'b0;
    lk_ready   = 1'b0;
    wr_ready   = 1'b0;
    sram_wen   = 1'b0;
    sram_addr  = addr_q;
    sram_wdata = '0;

    unique case (state_q)
      SWEEP: begin
        // One zero write per cycle; requests are held off and flush_req ignored.
        sram_wen = 1'b1;
        sram_addr = cnt_q;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      IDLE: begin
        // Fixed priority: a pending write blocks the lookup this cycle.
        wr_ready = 1'b1;
        lk_ready = !wr_valid;
        if (wr_valid) begin
          sram_wen   = 1'b1;
          sram_addr  = wr_idx;
          sram_wdata = wr_entry;
        end else if (lk_valid) begin
          sram_addr  = lk_idx;
          tag_d      = lk_tag;
          rsp_pend_d = 1'b1;
        end
        // The access above is still serviced; the sweep starts next cycle.
        if (flush_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
    endcase

    // Idle cycles keep presenting the last address to the array.
    addr_d = sram_addr;
  end

  // State registers with synchronous reset back into a fresh sweep.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every flop samples the values
    // from before this edge regardless of statement order.
    if (rst) begin
      state_q    <= SWEEP;
      cnt_q      <= '0;
      tag_q      <= '0;
      addr_q     <= '0;
      rsp_pend_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      addr_q     <= addr_d;
      rsp_pend_q <= rsp_pend_d;
      done_q     <= done_d;
    end
  end

  // The array registers its read data, so the response is formed directly
  // from sram_rdata in the cycle after the lookup; it is forced to zero when
  // no response is pending so undefined array output never leaks out.
  assign rd_entry   = tag_entry_t'(sram_rdata);
  assign rsp_valid  = rsp_pend_q;
  assign rsp_entry  = rsp_pend_q ? sram_rdata : '0;
  assign rsp_hit    = rsp_pend_q && rd_entry.valid && (rd_entry.tag == tag_q);

  assign flush_busy = (state_q == SWEEP);
  assign flush_done = done_q;

endmodule
